// File: rtl/timer_share_arbiter.sv
// rtl/timer_share_arbiter.sv - round-robin owner selection for one shared prescaled countdown timer
module timer_share_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 16,
  parameter int PW   = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*CW-1:0] req_count_i,
  input  logic [PW-1:0]     prescale_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   done_o,
  output logic              busy_o,
  output logic [CW-1:0]     count_o
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PW-1:0]   plat_q, plat_d;

  logic            found;
  logic [IW-1:0]   win;
  logic [CW-1:0]   ld_count;
  logic [IW-1:0]   owner_nxt;

  // First requesting index at or after ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign ld_count  = req_count_i[int'(win)*CW +: CW];
  assign owner_nxt = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    presc_d = presc_q;
    plat_d  = plat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d      = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          count_d      = ld_count;
          plat_d       = prescale_i;
          presc_d      = '0;
          if (ld_count == '0) begin
            state_d     = DONE;
            done_d[win] = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        // Owner withdrawal wins over a final tick landing in the same cycle
        if (!req_i[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = owner_nxt;
        end else if (presc_q == plat_q) begin
          presc_d = '0;
          count_d = count_q - 1'b1;
          if (count_q == CW'(1)) begin
            state_d = DONE;
            done_d  = grant_q;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = owner_nxt;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      plat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      presc_q <= presc_d;
      plat_q  <= plat_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != IDLE);
  assign count_o = count_q;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// tb/tb_timer_share_arbiter.sv - scoreboard bench for the shared timer arbiter
module tb_timer_share_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 16;
  localparam int PW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*CW-1:0] req_count = '0;
  logic [PW-1:0]     prescale = '0;
  logic [NREQ-1:0]   grant_o;
  logic [NREQ-1:0]   done_o;
  logic              busy_o;
  logic [CW-1:0]     count_o;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [NREQ-1:0] mask;
    int              cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  timer_share_arbiter #(.NREQ(NREQ), .CW(CW), .PW(PW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req_i       (req),
    .req_count_i (req_count),
    .prescale_i  (prescale),
    .grant_o     (grant_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Park on the falling edge inside absolute cycle c
  task automatic wait_cyc(input int c);
    while (cyc < c || clk) @(negedge clk);
  endtask

  task automatic set_cnt(input int k, input logic [CW-1:0] v);
    req_count[k*CW +: CW] = v;
  endtask

  task automatic push_done(input logic [NREQ-1:0] m, input int c);
    exp_t x;
    x.mask = m;
    x.cyc  = c;
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (done_o != '0) begin
      if (sb_q.size() == 0) begin
        check_val("done_unexpected", 32'(done_o), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check_val("done_mask", 32'(done_o), 32'(e.mask));
        check_val("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_grant", 32'(grant_o), 32'h0);
    check_val("rst_done", 32'(done_o), 32'h0);
    check_val("rst_busy", 32'(busy_o), 32'h0);
    check_val("rst_count", 32'(count_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request, P=0, count 3
    @(posedge clk); #1;
    t0 = cyc;
    set_cnt(0, 3);
    prescale = 0;
    req = 4'b0001;
    push_done(4'b0001, t0 + 4);
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(t0 + k);
      check_val("t1_grant", 32'(grant_o), 32'h1);
      check_val("t1_busy", 32'(busy_o), 32'h1);
      if (k <= 3) check_val("t1_count", 32'(count_o), 32'(4 - k));
    end
    req = '0;
    wait_cyc(t0 + 5);
    check_val("t1_busy_fall", 32'(busy_o), 32'h0);
    check_val("t1_grant_fall", 32'(grant_o), 32'h0);

    // Prescaled delay, prescale change mid-count ignored
    @(posedge clk); #1;
    t0 = cyc;
    set_cnt(1, 2);
    prescale = 2;
    req = 4'b0010;
    push_done(4'b0010, t0 + 7);
    wait_cyc(t0 + 1);
    check_val("t2_grant", 32'(grant_o), 32'h2);
    check_val("t2_count_c1", 32'(count_o), 32'h2);
    wait_cyc(t0 + 3);
    check_val("t2_count_c3", 32'(count_o), 32'h2);
    prescale = 0;
    wait_cyc(t0 + 4);
    check_val("t2_count_c4", 32'(count_o), 32'h1);
    wait_cyc(t0 + 6);
    check_val("t2_count_c6", 32'(count_o), 32'h1);
    check_val("t2_grant_c6", 32'(grant_o), 32'h2);
    wait_cyc(t0 + 7);
    check_val("t2_count_c7", 32'(count_o), 32'h0);
    req = '0;
    wait_cyc(t0 + 8);
    check_val("t2_busy_fall", 32'(busy_o), 32'h0);

    // Round robin with 0101 held
    do_reset();
    @(posedge clk); #1;
    t0 = cyc;
    set_cnt(0, 1);
    set_cnt(2, 1);
    prescale = 0;
    req = 4'b0101;
    for (int r = 0; r < 4; r++)
      push_done((r % 2 == 0) ? 4'b0001 : 4'b0100, t0 + 3*r + 2);
    for (int r = 0; r < 4; r++) begin
      wait_cyc(t0 + 3*r + 1);
      check_val("t3_grant", 32'(grant_o), (r % 2 == 0) ? 32'h1 : 32'h4);
      wait_cyc(t0 + 3*r + 2);
      if (r == 3) req = '0;
      wait_cyc(t0 + 3*r + 3);
      check_val("t3_idle_gap", 32'(busy_o), 32'h0);
    end

    // Zero count goes straight to DONE
    @(posedge clk); #1;
    t0 = cyc;
    set_cnt(3, 0);
    req = 4'b1000;
    push_done(4'b1000, t0 + 1);
    wait_cyc(t0 + 1);
    check_val("t4_grant", 32'(grant_o), 32'h8);
    check_val("t4_busy", 32'(busy_o), 32'h1);
    req = '0;
    wait_cyc(t0 + 2);
    check_val("t4_idle", 32'(busy_o), 32'h0);
    check_val("t4_grant_off", 32'(grant_o), 32'h0);

    // Abort by owner, pending requester 1 follows
    @(posedge clk); #1;
    t0 = cyc;
    set_cnt(0, 10);
    set_cnt(1, 1);
    req = 4'b0011;
    wait_cyc(t0 + 1);
    check_val("t5_grant", 32'(grant_o), 32'h1);
    check_val("t5_count_c1", 32'(count_o), 32'd10);
    wait_cyc(t0 + 4);
    check_val("t5_count_c4", 32'(count_o), 32'd7);
    req = 4'b0010;
    push_done(4'b0010, t0 + 7);
    wait_cyc(t0 + 5);
    check_val("t5_abort_busy", 32'(busy_o), 32'h0);
    check_val("t5_abort_grant", 32'(grant_o), 32'h0);
    check_val("t5_abort_count", 32'(count_o), 32'd7);
    wait_cyc(t0 + 6);
    check_val("t5_next_grant", 32'(grant_o), 32'h2);
    check_val("t5_next_count", 32'(count_o), 32'd1);
    wait_cyc(t0 + 7);
    req = '0;
    wait_cyc(t0 + 8);
    check_val("t5_idle", 32'(busy_o), 32'h0);

    // Reset mid-count clears outputs and pointer
    @(posedge clk); #1;
    t0 = cyc;
    set_cnt(2, 5);
    req = 4'b0100;
    wait_cyc(t0 + 1);
    check_val("t6_grant", 32'(grant_o), 32'h4);
    wait_cyc(t0 + 3);
    check_val("t6_count_c3", 32'(count_o), 32'd3);
    rst = 1'b1;
    wait_cyc(t0 + 4);
    check_val("t6_rst_grant", 32'(grant_o), 32'h0);
    check_val("t6_rst_done", 32'(done_o), 32'h0);
    check_val("t6_rst_busy", 32'(busy_o), 32'h0);
    check_val("t6_rst_count", 32'(count_o), 32'h0);
    rst = 1'b0;
    set_cnt(0, 1);
    set_cnt(3, 1);
    req = 4'b1001;
    push_done(4'b0001, t0 + 6);
    wait_cyc(t0 + 5);
    check_val("t6_ptr_grant", 32'(grant_o), 32'h1);
    wait_cyc(t0 + 6);
    req = '0;
    wait_cyc(t0 + 7);
    check_val("t6_idle", 32'(busy_o), 32'h0);

    repeat (5) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
